alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised successor to the team's 4-bit combinational ALU.
- Same 16-operation set at configurable WIDTH, with status flags (C, Z, N, V).
- Two-stage registered pipeline with valid/ready handshakes on input and output.
- Sits between operand-fetch logic and the register-file writeback in the datapath.

Parameters:
- WIDTH, 8: operand/result width in bits (>=2).

Ports:
- clk  input  1  rising-edge clock (the block's only clock).
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand beat present.
- in_ready  output  1  block can accept a beat this cycle.
- in_op  input  4  operation select.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts result.
- out_res  output  WIDTH  result.
- out_flags  output  4  {C,Z,N,V}; bit3=C, bit0=V.

Behaviour:
- Reset: one clock, synchronous active-high, rst. While rst is high at a rising edge, all valid bits clear; out_valid=0, out_res=0, out_flags=0; in-flight ops are discarded. in_ready=1 in the first cycle after reset.
- Opcodes. All arithmetic is mod 2^WIDTH. For ops 0000-0110 the arithmetic is done in WIDTH+1 bits.
  - 0000: A+B
  - 0001: A+B+1
  - 0010: A-B
  - 0011: A-B-1
  - 0100: A
  - 0101: A+1
  - 0110: A-1
  - 0111: B (pass B)
  - 1000: A&B
  - 1001: A|B
  - 1010: A^B
  - 1011: ~A
  - 1100: ~(A&B)
  - 1101: ~(A|B)
  - 1110: A>>1, logical, MSB<-0
  - 1111: A<<1, LSB<-0
- C flag:
  - Add ops (0000, 0001, 0101): carry out, bit WIDTH of the sum.
  - Sub ops (0010, 0011, 0110): borrow; C=1 iff unsigned A < subtrahend+borrow-in.
  - 1110: A[0]. 1111: A[WIDTH-1].
  - All other ops: 0.
- Z flag: result==0. N flag: result[WIDTH-1].
- V flag: two's-complement signed overflow for ops 0000-0011, 0101 and 0110; 0 otherwise.
- Pipeline, stage 1 (S1): a beat is accepted when in_valid && in_ready. op/a/b are registered into S1 and v1 is set.
- Pipeline, stage 2 (S2): S1 advances into S2 when v1 && (!v2 || out_ready). alu_core evaluates the S1 operands, and result plus flags are registered in S2.
- Ready chain:
  - s2_free = !v2 || out_ready.
  - in_ready = !v1 || s2_free.
  - The chain is combinational from out_ready; no skid buffer.
- Latency: 2 cycles from the acceptance edge to out_valid, with no stalls. Throughput is 1 op/cycle when out_ready stays high.
- Stall: while out_valid && !out_ready, out_res and out_flags hold stable. S1 holds too, so at most 2 ops are in flight.
- Simultaneous events: in the same cycle, S2 may drain, S1 may move into S2 and a new beat may enter S1, with no bubble.
- Empty pipeline: out_valid=0. out_res and out_flags keep their last value and are don't-care to consumers.
- Reset mid-operation: all in-flight beats are dropped, with no partial output.

Optional Feature:
- Macro: ALU_PIPE_SAT_EN.
- Defined: unsigned saturation on ops 0000, 0001, 0101 (on carry, result = all-ones) and ops 0010, 0011, 0110 (on borrow, result = 0). C still reports the raw carry or borrow. Z and N are computed on the saturated result. V is unchanged (raw).
- Undefined: wrap-around as specified above. No extra logic or ports in either build.

Decomposition:
- Package alu_pkg:
  - 4-bit opcode localparams: OP_ADD, OP_ADC, OP_SUB, OP_SBB, OP_PASSA, OP_INC, OP_DEC, OP_PASSB, OP_AND, OP_OR, OP_XOR, OP_NOTA, OP_NAND, OP_NOR, OP_SHR, OP_SHL.
  - Flag index constants: FLAG_C=3, FLAG_Z=2, FLAG_N=1, FLAG_V=0.
- Sub-module alu_core: purely combinational, WIDTH-parametrised. Takes op/a/b and produces res/flags, including the saturation option. alu_pipe holds only the registers and the handshake.

Test Plan:
- WIDTH=8, out_ready=1: ADD 0xFF+0x01 -> after 2 cycles res=0x00, C=1, Z=1, N=0, V=0. With ALU_PIPE_SAT_EN: res=0xFF, C=1, Z=0, N=1.
- SUB 0x80-0x01 -> res=0x7F, C=0, V=1, N=0. DEC 0x00 -> res=0xFF, C=1, N=1, V=0.
- SHR 0x81 -> res=0x40, C=1. SHL 0x81 -> res=0x02, C=1. PASSB with b=0x00 -> Z=1, C=0.
- Back-to-back: 4 beats on consecutive cycles with out_ready=1 -> 4 results on consecutive cycles starting 2 cycles after the first, in order, with in_ready constantly 1.
- Backpressure: out_ready=0 for 5 cycles after 3 beats are offered -> exactly 2 accepted, in_ready=0 from the third offer, out_res stable. Releasing out_ready drains both in order with no loss or duplication.
- rst asserted for 1 cycle with 2 ops in flight -> the next cycle has out_valid=0, out_res=0, out_flags=0 and in_ready=1; neither dropped op ever appears.

Source files
------------

// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ALU: the 4-bit opcode map, the bit
// positions of the status flags inside the 4-bit flag vector, and small
// helpers that classify opcodes into the adder and subtractor groups.
//
// Configuration macro (used by alu_core): ALU_PIPE_SAT_EN
// -----------------------------------------------------------------------------
package alu_pkg;

  // Opcode map (4-bit operation select).
  localparam logic [3:0] OP_ADD   = 4'b0000;  // A + B
  localparam logic [3:0] OP_ADC   = 4'b0001;  // A + B + 1
  localparam logic [3:0] OP_SUB   = 4'b0010;  // A - B
  localparam logic [3:0] OP_SBB   = 4'b0011;  // A - B - 1
  localparam logic [3:0] OP_PASSA = 4'b0100;  // A
  localparam logic [3:0] OP_INC   = 4'b0101;  // A + 1
  localparam logic [3:0] OP_DEC   = 4'b0110;  // A - 1
  localparam logic [3:0] OP_PASSB = 4'b0111;  // B
  localparam logic [3:0] OP_AND   = 4'b1000;  // A & B
  localparam logic [3:0] OP_OR    = 4'b1001;  // A | B
  localparam logic [3:0] OP_XOR   = 4'b1010;  // A ^ B
  localparam logic [3:0] OP_NOTA  = 4'b1011;  // ~A
  localparam logic [3:0] OP_NAND  = 4'b1100;  // ~(A & B)
  localparam logic [3:0] OP_NOR   = 4'b1101;  // ~(A | B)
  localparam logic [3:0] OP_SHR   = 4'b1110;  // A >> 1, logical
  localparam logic [3:0] OP_SHL   = 4'b1111;  // A << 1

  // Flag vector layout: {C, Z, N, V}.
  localparam int FLAG_C = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  // Ops whose result comes from the adder (C = carry out).
  function automatic logic is_add_op(input logic [3:0] op);
    return (op == OP_ADD) || (op == OP_ADC) || (op == OP_INC);
  endfunction

  // Ops whose result comes from the subtractor (C = borrow out).
  function automatic logic is_sub_op(input logic [3:0] op);
    return (op == OP_SUB) || (op == OP_SBB) || (op == OP_DEC);
  endfunction

endpackage : alu_pkg

// File: rtl/alu_core.sv
// -----------------------------------------------------------------------------
// alu_core
// Purely combinational WIDTH-bit ALU: 16 operations plus {C,Z,N,V} flags.
// Arithmetic ops are evaluated in WIDTH+1 bits so the extra bit is the raw
// carry (add group) or borrow (sub group).
//
// Configuration macro: ALU_PIPE_SAT_EN
//   defined   : add group saturates to all-ones on carry, sub group saturates
//               to zero on borrow; C and V stay raw, Z and N follow the
//               saturated result.
//   undefined : plain wrap-around arithmetic.
//
// Ports
//   op    in  [3:0]        operation select (see alu_pkg)
//   a     in  [WIDTH-1:0]  operand A
//   b     in  [WIDTH-1:0]  operand B
//   res   out [WIDTH-1:0]  result
//   flags out [3:0]        {C,Z,N,V}
// -----------------------------------------------------------------------------
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int MSB = WIDTH - 1;

  logic [WIDTH-1:0] y;        // second arithmetic operand (B, or 0 for INC/DEC)
  logic             cin;      // carry-in for add group, borrow-in for sub group
  logic [WIDTH:0]   add_x;
  logic [WIDTH:0]   sub_x;
  logic [WIDTH-1:0] res_raw;
  logic             c_flag;
  logic             v_flag;

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can
    // leave one unassigned and no latch is inferred.
    y       = '0;
    cin     = 1'b0;
    res_raw = '0;
    c_flag  = 1'b0;
    v_flag  = 1'b0;

    // INC/DEC reuse the adder/subtractor with y=0 and the +1 coming from cin.
    case (op)
      OP_ADD, OP_SUB: y = b;
      OP_ADC, OP_SBB: begin
        y   = b;
        cin = 1'b1;
      end
      OP_INC, OP_DEC: cin = 1'b1;
      default: ;
    endcase

    add_x = {1'b0, a} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    // A wrapped-negative difference sets bit WIDTH, which is exactly the
    // borrow: A < y + cin.
    sub_x = {1'b0, a} - {1'b0, y} - {{WIDTH{1'b0}}, cin};

    if (is_add_op(op)) begin
      res_raw = add_x[WIDTH-1:0];
      c_flag  = add_x[WIDTH];
      // Overflow: operands share a sign and the result sign differs.
      v_flag  = (a[MSB] == y[MSB]) && (res_raw[MSB] != a[MSB]);
    end else if (is_sub_op(op)) begin
      res_raw = sub_x[WIDTH-1:0];
      c_flag  = sub_x[WIDTH];
      // Overflow: operand signs differ and the result sign leaves A's.
      v_flag  = (a[MSB] != y[MSB]) && (res_raw[MSB] != a[MSB]);
    end else begin
      case (op)
        OP_PASSA: res_raw = a;
        OP_PASSB: res_raw = b;
        OP_AND:   res_raw = a & b;
        OP_OR:    res_raw = a | b;
        OP_XOR:   res_raw = a ^ b;
        OP_NOTA:  res_raw = ~a;
        OP_NAND:  res_raw = ~(a & b);
        OP_NOR:   res_raw = ~(a | b);
        OP_SHR: begin
          res_raw = {1'b0, a[WIDTH-1:1]};
          c_flag  = a[0];
        end
        OP_SHL: begin
          res_raw = {a[WIDTH-2:0], 1'b0};
          c_flag  = a[MSB];
        end
        default: res_raw = '0;
      endcase
    end

    res = res_raw;
`ifdef ALU_PIPE_SAT_EN
    if (c_flag && is_add_op(op)) begin
      res = '1;
    end else if (c_flag && is_sub_op(op)) begin
      res = '0;
    end
`endif

    flags         = '0;
    flags[FLAG_C] = c_flag;
    flags[FLAG_Z] = (res == '0);
    flags[FLAG_N] = res[MSB];
    flags[FLAG_V] = v_flag;
  end

endmodule : alu_core

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Two-stage pipelined ALU with valid/ready handshakes on both sides.
//   S1: registers the accepted op/a/b beat.
//   S2: registers the alu_core result and flags computed from S1.
// The ready chain is combinational from out_ready (no skid buffer), so one op
// per cycle flows with out_ready high and at most two ops are held on a stall.
//
// Configuration macro: ALU_PIPE_SAT_EN (saturating arithmetic, see alu_core)
//
// Ports
//   clk        in               rising-edge clock
//   rst        in               synchronous active-high reset
//   in_valid   in               operand beat present
//   in_ready   out              beat can be accepted this cycle
//   in_op      in  [3:0]        operation select
//   in_a       in  [WIDTH-1:0]  operand A
//   in_b       in  [WIDTH-1:0]  operand B
//   out_valid  out              result beat present
//   out_ready  in               downstream accepts result
//   out_res    out [WIDTH-1:0]  result
//   out_flags  out [3:0]        {C,Z,N,V}
// -----------------------------------------------------------------------------
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [3:0]       out_flags
);

  // Stage 1 state
  logic             v1_q,  v1_d;
  logic [3:0]       op1_q, op1_d;
  logic [WIDTH-1:0] a1_q,  a1_d;
  logic [WIDTH-1:0] b1_q,  b1_d;

  // Stage 2 state
  logic             v2_q,     v2_d;
  logic [WIDTH-1:0] res2_q,   res2_d;
  logic [3:0]       flags2_q, flags2_d;

  // Handshake terms
  logic s2_free;
  logic accept;
  logic advance;

  logic [WIDTH-1:0] core_res;
  logic [3:0]       core_flags;

  alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op    (op1_q),
    .a     (a1_q),
    .b     (b1_q),
    .res   (core_res),
    .flags (core_flags)
  );

  always_comb begin
    // S2 can take a new beat when empty or when its beat leaves this cycle;
    // S1 can take a new beat when empty or when its beat moves into S2.
    s2_free  = !v2_q || out_ready;
    in_ready = !v1_q || s2_free;
    accept   = in_valid && in_ready;
    advance  = v1_q && s2_free;

    v1_d     = v1_q;
    op1_d    = op1_q;
    a1_d     = a1_q;
    b1_d     = b1_q;
    v2_d     = v2_q;
    res2_d   = res2_q;
    flags2_d = flags2_q;

    // S1: a new beat wins over the leaving one, so drain and refill in the
    // same cycle keep v1 set with no bubble.
    if (advance) begin
      v1_d = 1'b0;
    end
    if (accept) begin
      v1_d  = 1'b1;
      op1_d = in_op;
      a1_d  = in_a;
      b1_d  = in_b;
    end

    // S2: data only changes on advance, so a stalled result holds stable and
    // an empty stage keeps its last value.
    if (out_ready) begin
      v2_d = 1'b0;
    end
    if (advance) begin
      v2_d     = 1'b1;
      res2_d   = core_res;
      flags2_d = core_flags;
    end
  end

  // NOTE: the datapath registers are reset along with the valid bits because
  // out_res and out_flags must read zero right after reset, not just be
  // marked invalid.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q     <= 1'b0;
      op1_q    <= '0;
      a1_q     <= '0;
      b1_q     <= '0;
      v2_q     <= 1'b0;
      res2_q   <= '0;
      flags2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge value of every other register.
      v1_q     <= v1_d;
      op1_q    <= op1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      v2_q     <= v2_d;
      res2_q   <= res2_d;
      flags2_q <= flags2_d;
    end
  end

  assign out_valid = v2_q;
  assign out_res   = res2_q;
  assign out_flags = flags2_q;

endmodule : alu_pipe

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe at WIDTH=8. A negedge monitor logs every
// accepted input beat (converted to its expected result by an integer-level
// reference model) and every delivered output beat; the test tasks compare
// the two logs and check handshake/timing properties inline.
// Honours ALU_PIPE_SAT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int W    = 8;
  localparam int MAXU = 2**W - 1;
  localparam int MAXS = 2**(W-1) - 1;
  localparam int MINS = -(2**(W-1));

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_op;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_res;
  logic [3:0]   out_flags;

  alu_pipe #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_res   (out_res),
    .out_flags (out_flags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic [3:0]   flags;
    int           cyc;
  } beat_t;

  beat_t exp_q[$];
  beat_t got_q[$];

  int tests = 0;
  int fails = 0;

  // Reference model: exact integer arithmetic, then wrap/saturate to W bits.
  function automatic beat_t model(input logic [3:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
    beat_t        r;
    int           ua, ub, sa, sb, u, s;
    logic [W-1:0] res;
    logic         c, v;
    bit           arith;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    u = 0; s = 0; c = 1'b0; v = 1'b0; res = '0; arith = 1'b1;
    case (op)
      OP_ADD:  begin u = ua + ub;     s = sa + sb;     end
      OP_ADC:  begin u = ua + ub + 1; s = sa + sb + 1; end
      OP_SUB:  begin u = ua - ub;     s = sa - sb;     end
      OP_SBB:  begin u = ua - ub - 1; s = sa - sb - 1; end
      OP_INC:  begin u = ua + 1;      s = sa + 1;      end
      OP_DEC:  begin u = ua - 1;      s = sa - 1;      end
      default: arith = 1'b0;
    endcase
    if (arith) begin
      c   = (u > MAXU) || (u < 0);
      v   = (s > MAXS) || (s < MINS);
      res = W'(u);
`ifdef ALU_PIPE_SAT_EN
      if (c) res = (u > MAXU) ? '1 : '0;
`endif
    end else begin
      case (op)
        OP_PASSA: res = a;
        OP_PASSB: res = b;
        OP_AND:   res = a & b;
        OP_OR:    res = a | b;
        OP_XOR:   res = a ^ b;
        OP_NOTA:  res = ~a;
        OP_NAND:  res = ~(a & b);
        OP_NOR:   res = ~(a | b);
        OP_SHR:   begin res = W'(ua / 2); c = (ua % 2) == 1; end
        OP_SHL:   begin res = W'(ua * 2); c = ua > MAXS;      end
        default:  res = '0;
      endcase
    end
    r.res   = res;
    r.flags = {c, (res == '0), res[W-1], v};
    r.cyc   = 0;
    return r;
  endfunction

  // Monitor: logs transfers on both ports at the negedge before the edge
  // that performs them.
  always @(negedge clk) begin
    beat_t e;
    beat_t g;
    if (!rst) begin
      if (in_valid && in_ready) begin
        e     = model(in_op, in_a, in_b);
        e.cyc = cyc;
        exp_q.push_back(e);
      end
      if (out_valid && out_ready) begin
        g.res   = out_res;
        g.flags = out_flags;
        g.cyc   = cyc;
        got_q.push_back(g);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stop input, open output, and wait (bounded) until every logged input
  // beat has come out.
  task automatic drain(input string name);
    bit done = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 30 && !done; i++) begin
      step();
      if (got_q.size() >= exp_q.size() && !out_valid) done = 1'b1;
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL %s drain timeout: got %0d beats, required %0d", name,
               got_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_op = '0; in_a = '0; in_b = '0;
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid: got %b, required 0", out_valid); end
    tests++;
    if (out_res !== '0) begin fails++; $display("FAIL reset out_res: got %h, required 00", out_res); end
    tests++;
    if (out_flags !== 4'b0) begin fails++; $display("FAIL reset out_flags: got %b, required 0000", out_flags); end
    tests++;
    if (in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready: got %b, required 1", in_ready); end
    step();
  endtask

  task automatic test_directed();
    logic [3:0]   t_op [6] = '{OP_ADD, OP_SUB, OP_DEC, OP_SHR, OP_SHL, OP_PASSB};
    logic [W-1:0] t_a  [6] = '{8'hFF, 8'h80, 8'h00, 8'h81, 8'h81, 8'h5A};
    logic [W-1:0] t_b  [6] = '{8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
`ifdef ALU_PIPE_SAT_EN
    logic [W-1:0] t_res[6] = '{8'hFF, 8'h7F, 8'h00, 8'h40, 8'h02, 8'h00};
    logic [3:0]   t_flg[6] = '{4'b1010, 4'b0001, 4'b1100, 4'b1000, 4'b1000, 4'b0100};
`else
    logic [W-1:0] t_res[6] = '{8'h00, 8'h7F, 8'hFF, 8'h40, 8'h02, 8'h00};
    logic [3:0]   t_flg[6] = '{4'b1100, 4'b0001, 4'b1010, 4'b1000, 4'b1000, 4'b0100};
`endif
    for (int i = 0; i < 6; i++) begin
      exp_q.delete(); got_q.delete();
      out_ready = 1'b1;
      in_valid = 1'b1; in_op = t_op[i]; in_a = t_a[i]; in_b = t_b[i];
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 10 && got_q.size() == 0; k++) step();
      tests++;
      if (got_q.size() != 1 || exp_q.size() != 1) begin
        fails++;
        $display("FAIL directed[%0d] beat count: got %0d out/%0d in, required 1/1", i,
                 got_q.size(), exp_q.size());
      end else begin
        tests++;
        if (got_q[0].res !== t_res[i]) begin
          fails++;
          $display("FAIL directed[%0d] op=%b res: got %h, required %h", i, t_op[i], got_q[0].res, t_res[i]);
        end
        tests++;
        if (got_q[0].flags !== t_flg[i]) begin
          fails++;
          $display("FAIL directed[%0d] op=%b flags: got %b, required %b", i, t_op[i], got_q[0].flags, t_flg[i]);
        end
        tests++;
        if (got_q[0].cyc - exp_q[0].cyc != 2) begin
          fails++;
          $display("FAIL directed[%0d] latency: got %0d, required 2", i, got_q[0].cyc - exp_q[0].cyc);
        end
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_op = 4'($urandom_range(15)); in_a = W'($urandom); in_b = W'($urandom);
      @(negedge clk);
      tests++;
      if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b in_ready[%0d]: got %b, required 1", i, in_ready); end
      step();
    end
    drain("b2b");
    tests++;
    if (got_q.size() != 4 || exp_q.size() != 4) begin
      fails++;
      $display("FAIL b2b beat count: got %0d out/%0d in, required 4/4", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if (got_q[i].res !== exp_q[i].res || got_q[i].flags !== exp_q[i].flags ||
            got_q[i].cyc != exp_q[0].cyc + 2 + i) begin
          fails++;
          $display("FAIL b2b beat[%0d]: got %h/%b@%0d, required %h/%b@%0d", i, got_q[i].res,
                   got_q[i].flags, got_q[i].cyc, exp_q[i].res, exp_q[i].flags, exp_q[0].cyc + 2 + i);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [W-1:0] held_res;
    logic [3:0]   held_flags;
    held_res = '0; held_flags = '0;
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      // Beats 0 and 1 are distinct; from cycle 2 on the third beat is re-offered.
      if (i < 3) begin
        in_valid = 1'b1; in_op = 4'($urandom_range(15));
        in_a = W'($urandom); in_b = W'($urandom);
      end
      @(negedge clk);
      tests++;
      if (in_ready !== (i < 2)) begin
        fails++;
        $display("FAIL bp in_ready[%0d]: got %b, required %b", i, in_ready, i < 2);
      end
      if (i == 2) begin
        held_res = out_res; held_flags = out_flags;
        tests++;
        if (out_valid !== 1'b1 || exp_q.size() != 2 || out_res !== exp_q[0].res ||
            out_flags !== exp_q[0].flags) begin
          fails++;
          $display("FAIL bp stalled head: got v=%b %h/%b, required v=1 %h/%b", out_valid, out_res,
                   out_flags, exp_q.size() > 0 ? exp_q[0].res : 8'h00,
                   exp_q.size() > 0 ? exp_q[0].flags : 4'h0);
        end
      end else if (i > 2) begin
        tests++;
        if (out_res !== held_res || out_flags !== held_flags || out_valid !== 1'b1) begin
          fails++;
          $display("FAIL bp hold[%0d]: got v=%b %h/%b, required v=1 %h/%b", i, out_valid, out_res,
                   out_flags, held_res, held_flags);
        end
      end
      step();
    end
    drain("bp");
    tests++;
    if (exp_q.size() != 2 || got_q.size() != 2) begin
      fails++;
      $display("FAIL bp beat count: got %0d out/%0d in, required 2/2", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if (got_q[i].res !== exp_q[i].res || got_q[i].flags !== exp_q[i].flags) begin
          fails++;
          $display("FAIL bp beat[%0d]: got %h/%b, required %h/%b", i, got_q[i].res, got_q[i].flags,
                   exp_q[i].res, exp_q[i].flags);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] corner [4] = '{8'h00, 8'h7F, 8'h80, 8'hFF};
    int errs = 0;
    exp_q.delete(); got_q.delete();
    for (int i = 0; i < 300; i++) begin
      in_valid  = ($urandom_range(3) != 0);
      out_ready = ($urandom_range(3) != 0);
      in_op     = 4'($urandom_range(15));
      in_a      = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
      in_b      = ($urandom_range(3) == 0) ? corner[$urandom_range(3)] : W'($urandom);
      step();
    end
    drain("random");
    tests++;
    if (got_q.size() != exp_q.size() || exp_q.size() < 50) begin
      fails++;
      $display("FAIL random beat count: got %0d out, required %0d (>=50)", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        tests++;
        if (got_q[i].res !== exp_q[i].res || got_q[i].flags !== exp_q[i].flags) begin
          fails++;
          errs++;
          if (errs <= 10)
            $display("FAIL random beat[%0d]: got %h/%b, required %h/%b", i, got_q[i].res,
                     got_q[i].flags, exp_q[i].res, exp_q[i].flags);
        end
      end
    end
  endtask

  task automatic test_reset_midflight();
    exp_q.delete(); got_q.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = OP_ADD; in_a = 8'h12; in_b = 8'h34;
    step();
    in_op = OP_OR; in_a = 8'hA5; in_b = 8'h0F;
    step();
    in_valid = 1'b0;
    tests++;
    if (out_valid !== 1'b1 || exp_q.size() != 2) begin
      fails++;
      $display("FAIL midrst setup: got v=%b accepted=%0d, required v=1 accepted=2", out_valid, exp_q.size());
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++;
    if (out_valid !== 1'b0 || out_res !== '0 || out_flags !== 4'b0 || in_ready !== 1'b1) begin
      fails++;
      $display("FAIL midrst state: got v=%b %h/%b rdy=%b, required v=0 00/0000 rdy=1", out_valid,
               out_res, out_flags, in_ready);
    end
    exp_q.delete(); got_q.delete();
    out_ready = 1'b1;
    repeat (6) step();
    tests++;
    if (got_q.size() != 0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL midrst ghost output: got %0d beats v=%b, required 0 beats v=0", got_q.size(), out_valid);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish before 2 ms");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_alu_pipe
